uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

UART transmitter that builds an 11-bit frame from an 8-bit data byte and shifts it out serially. The frame is start(0), data[7:0] LSB-first, parity, stop(1). It is bit-for-bit the format expected by the receive-side SIPO/deframer path (frame bit 0 = start, bits 8:1 = data, bit 9 = parity, bit 10 = stop). It sits between the processor's UART register interface and the TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_start`  in  1  request to send `tx_data`; accepted only when `tx_ready`=1.
- `tx_data`  in  8  byte to send; sampled only in the accept cycle.
- `tx_ready`  out  1  framer idle and able to accept a byte.
- `tx_busy`  out  1  frame in progress (equals !`tx_ready`).
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.
- `tx_serial`  out  1  serial line, idle high.

## Operation
- FSM states: IDLE, SEND, DONE.
- **IDLE**
  - `tx_ready`=1 and `tx_serial`=1.
  - When `tx_start`=1, latch frame = {1'b1, parity, `tx_data`, 1'b0} into the 11-bit shift register.
  - Clear the baud counter and bit index, then go to SEND.
- **SEND**
  - `tx_serial` = shift_reg[0].
  - The baud counter counts 0..`CLKS_PER_BIT`-1.
  - At terminal count, the shift register shifts right (fill 1), the counter wraps to 0 and the bit index increments.
  - At terminal count with bit index 10, go to DONE.
- **DONE**
  - `tx_serial`=1, `tx_done`=1 for exactly one cycle, `tx_ready`=0.
  - Unconditionally go to IDLE.
- Parity:
  - `PARITY_ODD`=0: parity = ^`tx_data`.
  - `PARITY_ODD`=1: parity = ~^`tx_data`.
- Ignored inputs:
  - `tx_start` during SEND or DONE is ignored. It is not queued and not an error.
  - `tx_data` changes after acceptance have no effect on the frame in flight.
- Reset values:
  - `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
  - State=IDLE; counter, index and shift register cleared (shift register cleared to all-ones).
- Reset asserted mid-frame: the line returns high immediately (asynchronously) and the partial frame is abandoned with no `tx_done`.

## Timing
- Accept cycle N (IDLE, `tx_start`=1): the start bit appears on `tx_serial` from cycle N+1.
- Each bit is held exactly `CLKS_PER_BIT` cycles.
- Frame bit k occupies cycles N+1+k·`CLKS_PER_BIT` .. N+(k+1)·`CLKS_PER_BIT`, for k=0..10.
- `tx_done` is high in cycle N+1+11·`CLKS_PER_BIT`. `tx_ready` returns in the following cycle.
- Minimum accept-to-accept spacing is 11·`CLKS_PER_BIT`+2 cycles. The line stays high for at least 1 cycle between back-to-back frames.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `tx_start` or `tx_data` to any output.
- Baud counter width is $clog2(`CLKS_PER_BIT`). Bit index width is 4 bits; values 11–15 are unreachable.

## Structure
- Shared package `uart_pkg`:
  - FRAME_W=11, START_IDX=0, DATA_LSB=1, DATA_MSB=8, PARITY_IDX=9, STOP_IDX=10. These are shared with the receive path.
  - Enum `tx_state_t` {IDLE, SEND, DONE}.
- Sub-module `uart_baud_gen`:
  - Parameter `CLKS_PER_BIT`; inputs `clk`, `reset`, `clear`; output `bit_tick` (1-cycle terminal-count pulse).
  - Reusable by the receive side.
- `uart_tx_framer` holds the FSM, the shift register and the bit index.

## Test plan
Bench uses `CLKS_PER_BIT`=4.

1. **Reset defaults.** Assert `reset` for 3 cycles, then release → `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
2. **Even-parity frame.** `PARITY_ODD`=0, send 0xA5 → wire bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles. `tx_done` pulses once at cycle N+45; `tx_ready` is high at N+46.
3. **Odd-parity frame.** `PARITY_ODD`=1, send 0x07 → parity bit (frame bit 9) is 0. With `PARITY_ODD`=0 the same byte gives parity bit 1.
4. **Ignored inputs while busy.** Hold `tx_start`=1 and change `tx_data` to 0x00 throughout a 0xFF frame → exactly one frame is sent, carrying 0xFF. The next frame is accepted only once `tx_ready`=1.
5. **Back-to-back frames.** Send 0x55, then 0xAA with `tx_start` held high → the second start bit falls exactly 2 cycles after the 0x55 stop bit ends (one DONE cycle plus one IDLE accept cycle). The round-trip through the SIPO/deframer recovers both bytes with correct parity.
6. **Reset mid-frame.** Assert `reset` during data bit 3 of 0x3C → `tx_serial`=1 in the same cycle and no `tx_done` pulse. After release, a new 0x81 frame is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Frame layout and TX state encoding, shared by the transmit and receive UART paths.
package uart_pkg;

    localparam int FRAME_W    = 11;
    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

    // Bit 0 goes on the wire first: start, data LSB-first, parity, stop.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data, input logic odd);
        return {1'b1, calc_parity(data, odd), data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each CLKS_PER_BIT-cycle bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == TERM) && !clear;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: latches a byte into an 11-bit frame and shifts it out LSB-first.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_serial
);

    tx_state_t            state_q;
    logic [FRAME_W-1:0]   shift_q;
    logic [3:0]           idx_q;
    logic                 bit_tick;
    logic                 baud_clear;

    // Counter is held at zero outside SEND so the first bit gets a full period.
    assign baud_clear = (state_q != SEND);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '1;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        shift_q <= build_frame(tx_data, PARITY_ODD != 0);
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bit_tick) begin
                        shift_q <= {1'b1, shift_q[FRAME_W-1:1]};
                        if (idx_q == 4'(STOP_IDX)) begin
                            idx_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The fill-with-ones shift leaves the register all-ones outside SEND,
    // so its LSB is the line level in every state, including under reset.
    assign tx_serial = shift_q[0];
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = !tx_ready;
    assign tx_done   = (state_q == DONE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with CLKS_PER_BIT=4, even and odd parity instances.
module tb_uart_tx_framer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       ready0, busy0, done0, ser0;
    logic       ready1, busy1, done1, ser1;
    logic       sel_odd;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) u_dut_even (
        .clk(clk), .reset(reset), .tx_start(start0), .tx_data(data0),
        .tx_ready(ready0), .tx_busy(busy0), .tx_done(done0), .tx_serial(ser0)
    );

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) u_dut_odd (
        .clk(clk), .reset(reset), .tx_start(start1), .tx_data(data1),
        .tx_ready(ready1), .tx_busy(busy1), .tx_done(done1), .tx_serial(ser1)
    );

    typedef struct {
        logic        odd;
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[6];

    function automatic logic get_ser();   return sel_odd ? ser1   : ser0;   endfunction
    function automatic logic get_ready(); return sel_odd ? ready1 : ready0; endfunction
    function automatic logic get_busy();  return sel_odd ? busy1  : busy0;  endfunction
    function automatic logic get_done();  return sel_odd ? done1  : done0;  endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel_odd) start1 = v; else start0 = v;
    endtask

    task automatic drive_data(input logic [7:0] d);
        if (sel_odd) data1 = d; else data0 = d;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!get_ready() && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " ready_wait"}, {31'd0, get_ready()}, 32'd1);
    endtask

    // Called at a negedge with tx_start already driven; the next posedge is the accept edge.
    task automatic check_frame(input string name, input logic [10:0] exp,
                               input bit hold, input logic [7:0] next_data);
        logic [10:0] rx;
        int          done_cnt;
        rx       = '0;
        done_cnt = 0;
        @(posedge clk);
        for (int j = 1; j <= 46; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (!hold) drive_start(1'b0);
                drive_data(next_data);
            end
            if (get_done()) done_cnt++;
            if (j <= 44) begin
                chk({name, " serial"}, {31'd0, get_ser()}, {31'd0, exp[(j-1)/CPB]});
                chk({name, " busy"}, {31'd0, get_busy()}, 32'd1);
                if ((j - 1) % CPB == CPB / 2) rx[(j-1)/CPB] = get_ser();
            end
            if (j == 45) begin
                chk({name, " done_pulse"}, {31'd0, get_done()}, 32'd1);
                chk({name, " ready_in_done"}, {31'd0, get_ready()}, 32'd0);
                chk({name, " serial_in_done"}, {31'd0, get_ser()}, 32'd1);
            end
            if (j == 46) begin
                chk({name, " ready_after"}, {31'd0, get_ready()}, 32'd1);
                chk({name, " done_after"}, {31'd0, get_done()}, 32'd0);
            end
        end
        chk({name, " done_count"}, done_cnt, 1);
        chk({name, " rx_frame"}, {21'd0, rx}, {21'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{1'b1, 8'h07, 11'b1_0_00000111_0};
        vecs[2] = '{1'b0, 8'h07, 11'b1_1_00000111_0};
        vecs[3] = '{1'b0, 8'h01, 11'b1_1_00000001_0};
        vecs[4] = '{1'b1, 8'hFF, 11'b1_1_11111111_0};
        vecs[5] = '{1'b1, 8'h80, 11'b1_0_10000000_0};

        reset   = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        data0   = 8'h00;
        data1   = 8'h00;
        sel_odd = 1'b0;

        // Reset defaults on both instances
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst even serial", {31'd0, ser0},   32'd1);
        chk("rst even ready",  {31'd0, ready0}, 32'd1);
        chk("rst even busy",   {31'd0, busy0},  32'd0);
        chk("rst even done",   {31'd0, done0},  32'd0);
        chk("rst odd serial",  {31'd0, ser1},   32'd1);
        chk("rst odd ready",   {31'd0, ready1}, 32'd1);
        chk("rst odd busy",    {31'd0, busy1},  32'd0);
        chk("rst odd done",    {31'd0, done1},  32'd0);

        // Single frames, both parity modes
        for (int v = 0; v < 6; v++) begin
            sel_odd = vecs[v].odd;
            wait_ready($sformatf("vec%0d", v));
            drive_data(vecs[v].data);
            drive_start(1'b1);
            check_frame($sformatf("vec%0d", v), vecs[v].frame, 1'b0, ~vecs[v].data);
        end

        // Start held and data changed during a frame: one 0xFF frame, then 0x00 once ready
        sel_odd = 1'b0;
        wait_ready("hold");
        drive_data(8'hFF);
        drive_start(1'b1);
        check_frame("hold_ff", 11'b1_0_11111111_0, 1'b1, 8'h00);
        check_frame("hold_next", 11'b1_0_00000000_0, 1'b0, 8'h00);

        // Back-to-back: the second accept edge immediately follows the ready cycle
        wait_ready("b2b");
        drive_data(8'h55);
        drive_start(1'b1);
        check_frame("b2b_55", 11'b1_0_01010101_0, 1'b1, 8'hAA);
        check_frame("b2b_aa", 11'b1_0_10101010_0, 1'b0, 8'h00);

        // Reset during data bit 3 of 0x3C
        begin
            int done_seen;
            done_seen = 0;
            wait_ready("midrst");
            drive_data(8'h3C);
            drive_start(1'b1);
            @(posedge clk);
            for (int j = 1; j <= 18; j++) begin
                @(negedge clk);
                if (j == 1) drive_start(1'b0);
                if (get_done()) done_seen++;
            end
            chk("midrst busy_before", {31'd0, get_busy()}, 32'd1);
            reset = 1'b1;
            #1;
            chk("midrst serial_async", {31'd0, get_ser()},   32'd1);
            chk("midrst ready_async",  {31'd0, get_ready()}, 32'd1);
            chk("midrst busy_async",   {31'd0, get_busy()},  32'd0);
            repeat (2) begin
                @(negedge clk);
                if (get_done()) done_seen++;
            end
            reset = 1'b0;
            repeat (60) begin
                @(negedge clk);
                if (get_done()) done_seen++;
                chk("midrst serial_idle", {31'd0, get_ser()}, 32'd1);
            end
            chk("midrst no_done", done_seen, 0);
            chk("midrst ready_end", {31'd0, get_ready()}, 32'd1);
        end

        drive_data(8'h81);
        drive_start(1'b1);
        check_frame("post_rst_81", 11'b1_0_10000001_0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
